// File: rtl/cpu_run_controller.sv
// CPU run controller: gates the core clock enable for single step, N-cycle burst,
// continuous run and run-to-breakpoint, and synchronises the core reset.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE    0 | core stopped, commands accepted
// STEP    1 | single enable cycle
// BURST   2 | enable for the sampled burst length, breakpoint armed
// RUN     3 | enable until halt or breakpoint, breakpoint armed
// BP_HALT 4 | stopped on breakpoint, commands accepted
module cpu_run_controller #(
  parameter int XLEN        = 32,
  parameter int STEP_CNT_W  = 16,
  parameter int SYNC_STAGES = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  step_req,
  input  logic                  burst_req,
  input  logic [STEP_CNT_W-1:0] burst_count,
  input  logic                  run_req,
  input  logic                  halt_req,
  input  logic                  bp_enable,
  input  logic [XLEN-1:0]       bp_addr,
  input  logic [XLEN-1:0]       pc_value,
  output logic                  cpu_clk_enable,
  output logic                  cpu_reset,
  output logic [2:0]            state,
  output logic [STEP_CNT_W-1:0] steps_done,
  output logic                  bp_hit,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_STEP    = 3'd1,
    S_BURST   = 3'd2,
    S_RUN     = 3'd3,
    S_BP_HALT = 3'd4
  } state_t;

  localparam logic [STEP_CNT_W-1:0] CNT_ONE = STEP_CNT_W'(1);

  logic [SYNC_STAGES-1:0] rst_sync;

  state_t                  state_q, state_d;
  logic [STEP_CNT_W-1:0]   burst_left_q, burst_left_d;
  logic [STEP_CNT_W-1:0]   steps_q, steps_d;
  logic                    first_q, first_d;
  logic                    bp_hit_q, bp_hit_d;
  logic                    en_q, busy_q;
  logic                    active_d;
  logic                    accept;
  logic                    burst_ok;
  logic                    bp_trig;

  // Reset asserts asynchronously and releases after SYNC_STAGES clean edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync <= '1;
    end else begin
      rst_sync <= {rst_sync[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign cpu_reset = rst_sync[SYNC_STAGES-1];

  always_comb begin
    state_d      = state_q;
    burst_left_d = burst_left_q;
    first_d      = 1'b0;
    bp_hit_d     = bp_hit_q;
    accept       = 1'b0;
    burst_ok     = burst_req && (burst_count != '0);
    // First enable cycle of a run/burst is masked so a resume from the breakpoint PC advances.
    bp_trig      = en_q && bp_enable && (pc_value == bp_addr) && !first_q &&
                   ((state_q == S_BURST) || (state_q == S_RUN));

    case (state_q)
      S_IDLE, S_BP_HALT: begin
        if (halt_req) begin
          state_d  = S_IDLE;
          bp_hit_d = 1'b0;
        end else if (step_req) begin
          state_d = S_STEP;
          accept  = 1'b1;
        end else if (burst_ok) begin
          state_d      = S_BURST;
          burst_left_d = burst_count;
          first_d      = 1'b1;
          accept       = 1'b1;
        end else if (run_req) begin
          state_d = S_RUN;
          first_d = 1'b1;
          accept  = 1'b1;
        end
      end
      S_STEP: begin
        state_d = S_IDLE;
      end
      S_BURST: begin
        burst_left_d = burst_left_q - CNT_ONE;
        if (halt_req) begin
          state_d = S_IDLE;
        end else if (bp_trig) begin
          state_d  = S_BP_HALT;
          bp_hit_d = 1'b1;
        end else if (burst_left_q == CNT_ONE) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (halt_req) begin
          state_d = S_IDLE;
        end else if (bp_trig) begin
          state_d  = S_BP_HALT;
          bp_hit_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (accept) begin
      bp_hit_d = 1'b0;
    end

    if (accept) begin
      steps_d = '0;
    end else if (en_q && (steps_q != '1)) begin
      steps_d = steps_q + CNT_ONE;
    end else begin
      steps_d = steps_q;
    end

    active_d = (state_d == S_STEP) || (state_d == S_BURST) || (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      burst_left_q <= '0;
      steps_q      <= '0;
      first_q      <= 1'b0;
      bp_hit_q     <= 1'b0;
      en_q         <= 1'b0;
      busy_q       <= 1'b0;
    end else if (cpu_reset) begin
      state_q      <= S_IDLE;
      burst_left_q <= '0;
      steps_q      <= '0;
      first_q      <= 1'b0;
      bp_hit_q     <= 1'b0;
      en_q         <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_left_q <= burst_left_d;
      steps_q      <= steps_d;
      first_q      <= first_d;
      bp_hit_q     <= bp_hit_d;
      en_q         <= active_d;
      busy_q       <= active_d;
    end
  end

  assign cpu_clk_enable = en_q;
  assign busy           = busy_q;
  assign bp_hit         = bp_hit_q;
  assign steps_done     = steps_q;
  assign state          = state_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Scoreboard bench for cpu_run_controller: stimulus queues expected snapshots tagged with
// a cycle number, a negedge monitor pops and compares them against both DUT instances.
module tb_cpu_run_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        step_req, burst_req, run_req, halt_req, bp_enable;
  logic [15:0] burst_count;
  logic [31:0] bp_addr, pc_value;

  logic        cpu_clk_enable, cpu_reset, bp_hit, busy;
  logic [2:0]  state;
  logic [15:0] steps_done;

  logic        s_en, s_rst, s_bp, s_busy;
  logic [2:0]  s_state;
  logic [3:0]  s_steps;

  always #5 clk = ~clk;

  cpu_run_controller dut (
    .clk(clk), .reset_n(reset_n), .step_req(step_req), .burst_req(burst_req),
    .burst_count(burst_count), .run_req(run_req), .halt_req(halt_req),
    .bp_enable(bp_enable), .bp_addr(bp_addr), .pc_value(pc_value),
    .cpu_clk_enable(cpu_clk_enable), .cpu_reset(cpu_reset), .state(state),
    .steps_done(steps_done), .bp_hit(bp_hit), .busy(busy)
  );

  cpu_run_controller #(.STEP_CNT_W(4)) dut_sat (
    .clk(clk), .reset_n(reset_n), .step_req(step_req), .burst_req(burst_req),
    .burst_count(burst_count[3:0]), .run_req(run_req), .halt_req(halt_req),
    .bp_enable(bp_enable), .bp_addr(bp_addr), .pc_value(pc_value),
    .cpu_clk_enable(s_en), .cpu_reset(s_rst), .state(s_state),
    .steps_done(s_steps), .bp_hit(s_bp), .busy(s_busy)
  );

  typedef struct {
    int          cyc;
    string       name;
    logic        rst;
    logic [2:0]  st;
    logic        en;
    logic        bsy;
    logic        bph;
    logic [15:0] sd;
    bit          chk_sat;
    logic [3:0]  sd_sat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_at(input int off, input string nm, input logic r, input logic [2:0] st,
                           input logic en, input logic [15:0] sd, input logic bph,
                           input bit cs, input logic [3:0] ss);
    exp_t e;
    e.cyc     = cyc + off;
    e.name    = nm;
    e.rst     = r;
    e.st      = st;
    e.en      = en;
    e.bsy     = (st == 3'd1) || (st == 3'd2) || (st == 3'd3);
    e.bph     = bph;
    e.sd      = sd;
    e.chk_sat = cs;
    e.sd_sat  = ss;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      n_vec++;
      if (mon_e.cyc < cyc) begin
        n_err++;
        $display("FAIL %s: check for cycle %0d reached at cycle %0d", mon_e.name, mon_e.cyc, cyc);
      end else if (({cpu_reset, state, cpu_clk_enable, busy, bp_hit, steps_done} !==
                    {mon_e.rst, mon_e.st, mon_e.en, mon_e.bsy, mon_e.bph, mon_e.sd}) ||
                   (mon_e.chk_sat && (s_steps !== mon_e.sd_sat))) begin
        n_err++;
        $display("FAIL %s cyc=%0d got rst=%0b st=%0d en=%0b busy=%0b bp=%0b sd=%0d sat_sd=%0d exp rst=%0b st=%0d en=%0b busy=%0b bp=%0b sd=%0d sat_sd=%0d",
                 mon_e.name, cyc, cpu_reset, state, cpu_clk_enable, busy, bp_hit, steps_done,
                 s_steps, mon_e.rst, mon_e.st, mon_e.en, mon_e.bsy, mon_e.bph, mon_e.sd,
                 mon_e.sd_sat);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n     = 1'b0;
    step_req    = 1'b0;
    burst_req   = 1'b0;
    run_req     = 1'b0;
    halt_req    = 1'b0;
    bp_enable   = 1'b0;
    burst_count = '0;
    bp_addr     = '0;
    pc_value    = '0;

    // reset: two cycles low, release, cpu_reset drops on the third edge
    tick(); tick();
    expect_at(0, "reset_hold", 1, 0, 0, 0, 0, 1, 0);
    reset_n = 1'b1;
    expect_at(2, "reset_sync2", 1, 0, 0, 0, 0, 0, 0);
    expect_at(3, "reset_release", 0, 0, 0, 0, 0, 1, 0);
    repeat (5) tick();

    // single step
    step_req = 1'b1;
    expect_at(1, "step_on", 0, 1, 1, 0, 0, 0, 0);
    expect_at(2, "step_off", 0, 0, 0, 1, 0, 0, 0);
    tick(); step_req = 1'b0;
    repeat (3) tick();

    // burst of 5
    burst_count = 16'd5; burst_req = 1'b1;
    expect_at(1, "burst_first", 0, 2, 1, 0, 0, 0, 0);
    expect_at(5, "burst_last", 0, 2, 1, 4, 0, 0, 0);
    expect_at(6, "burst_done", 0, 0, 0, 5, 0, 0, 0);
    tick(); burst_req = 1'b0;
    repeat (7) tick();

    // burst of 0 is ignored
    burst_count = 16'd0; burst_req = 1'b1;
    expect_at(1, "burst_zero_a", 0, 0, 0, 5, 0, 0, 0);
    expect_at(2, "burst_zero_b", 0, 0, 0, 5, 0, 0, 0);
    tick(); burst_req = 1'b0;
    repeat (3) tick();

    // run to breakpoint at 0x40
    bp_enable = 1'b1; bp_addr = 32'h40; pc_value = 32'h30; run_req = 1'b1;
    expect_at(1, "run_first", 0, 3, 1, 0, 0, 0, 0);
    expect_at(3, "run_pre_bp", 0, 3, 1, 2, 0, 0, 0);
    expect_at(4, "bp_halt", 0, 4, 0, 3, 1, 0, 0);
    tick(); run_req = 1'b0; pc_value = 32'h38;
    tick(); pc_value = 32'h3c;
    tick(); pc_value = 32'h40;
    repeat (3) tick();

    // resume from breakpoint PC, step dropped while running, then halt
    run_req = 1'b1;
    expect_at(1, "resume_first", 0, 3, 1, 0, 0, 0, 0);
    expect_at(2, "resume_past_bp", 0, 3, 1, 1, 0, 0, 0);
    expect_at(3, "halt_run", 0, 0, 0, 2, 0, 0, 0);
    tick(); run_req = 1'b0; step_req = 1'b1;
    tick(); step_req = 1'b0; pc_value = 32'h44; halt_req = 1'b1;
    tick(); halt_req = 1'b0;
    repeat (3) tick();

    // simultaneous step + run: step wins
    step_req = 1'b1; run_req = 1'b1;
    expect_at(1, "simul_step", 0, 1, 1, 0, 0, 0, 0);
    expect_at(2, "simul_idle", 0, 0, 0, 1, 0, 0, 0);
    expect_at(3, "simul_stay", 0, 0, 0, 1, 0, 0, 0);
    tick(); step_req = 1'b0; run_req = 1'b0;
    repeat (4) tick();

    // breakpoint on last burst cycle, then halt clears bp_hit
    pc_value = 32'h0; burst_count = 16'd3; burst_req = 1'b1;
    expect_at(3, "burst_bp_last", 0, 2, 1, 2, 0, 0, 0);
    expect_at(4, "burst_bp_hit", 0, 4, 0, 3, 1, 0, 0);
    expect_at(5, "halt_in_bp", 0, 0, 0, 3, 0, 0, 0);
    tick(); burst_req = 1'b0;
    tick();
    tick(); pc_value = 32'h40;
    tick(); halt_req = 1'b1;
    tick(); halt_req = 1'b0;
    repeat (3) tick();

    // 20-cycle run: 4-bit instance saturates at 15
    bp_enable = 1'b0; pc_value = 32'h0; run_req = 1'b1;
    expect_at(16, "sat_reach", 0, 3, 1, 15, 0, 1, 15);
    expect_at(21, "sat_hold", 0, 0, 0, 20, 0, 1, 15);
    tick(); run_req = 1'b0;
    repeat (19) tick();
    halt_req = 1'b1;
    tick(); halt_req = 1'b0;
    repeat (3) tick();

    // reset mid-run aborts immediately
    run_req = 1'b1;
    expect_at(1, "pre_reset_run", 0, 3, 1, 0, 0, 0, 0);
    tick(); run_req = 1'b0;
    tick(); reset_n = 1'b0;
    expect_at(0, "async_abort", 1, 0, 0, 0, 0, 1, 0);
    tick(); reset_n = 1'b1;
    expect_at(2, "abort_sync2", 1, 0, 0, 0, 0, 0, 0);
    expect_at(3, "abort_release", 0, 0, 0, 0, 0, 1, 0);
    repeat (5) tick();

    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    if (sb.size() > 0) begin
      $display("FAIL drain: %0d checks pending, required 0", sb.size());
      n_vec += sb.size();
      n_err += sb.size();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
